// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline stage between instruction memory and decode. Each fetched
// instruction and its PC are captured and handed to decode through a
// valid/ready handshake on both sides. Storage is one main entry plus one
// skid entry. A decode stall therefore never drops a fetched instruction,
// and if_ready depends only on registered state.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   if_valid        fetch presents a valid instruction this cycle
//   if_instruction  fetched instruction word
//   if_pc           PC of the fetched instruction
//   if_ready        stage can accept an instruction this cycle
//   flush           discard every held instruction (branch/jump redirect)
//   id_ready        decode consumes the output pair this cycle
//   id_valid        output pair is valid
//   id_instruction  held instruction word
//   id_pc           held PC
//   id_opcode/id_rs/id_rt/id_rd/id_shamt/id_funct
//                   R-type fields sliced from id_instruction
//   id_is_rtype     id_valid and opcode == 0
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [INSTR_WIDTH-1:0] if_instruction,
    input  logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_ready,
    input  logic                   flush,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instruction,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [5:0]             id_opcode,
    output logic [4:0]             id_rs,
    output logic [4:0]             id_rt,
    output logic [4:0]             id_rd,
    output logic [4:0]             id_shamt,
    output logic [5:0]             id_funct,
    output logic                   id_is_rtype
);

    // Main entry drives the id_* outputs. Skid entry holds the overflow.
    logic                   m_valid_q, m_valid_d;
    logic [INSTR_WIDTH-1:0] m_instr_q, m_instr_d;
    logic [PC_WIDTH-1:0]    m_pc_q,    m_pc_d;
    logic                   s_valid_q, s_valid_d;
    logic [INSTR_WIDTH-1:0] s_instr_q, s_instr_d;
    logic [PC_WIDTH-1:0]    s_pc_q,    s_pc_d;

    logic accept_s;
    logic consume_s;

    // Handshake terms. if_ready comes from the skid flag only, so a decode
    // stall never reaches the fetch side combinationally.
    assign if_ready  = ~s_valid_q;
    assign accept_s  = if_valid & ~s_valid_q;
    assign consume_s = m_valid_q & id_ready;

    // Output view of the main entry. Field slices are valid regardless of id_valid.
    assign id_valid       = m_valid_q;
    assign id_instruction = m_instr_q;
    assign id_pc          = m_pc_q;
    assign id_opcode      = m_instr_q[31:26];
    assign id_rs          = m_instr_q[25:21];
    assign id_rt          = m_instr_q[20:16];
    assign id_rd          = m_instr_q[15:11];
    assign id_shamt       = m_instr_q[10:6];
    assign id_funct       = m_instr_q[5:0];
    assign id_is_rtype    = m_valid_q & (m_instr_q[31:26] == 6'b000000);

    // Next-state logic for the two-entry buffer. Flush beats accept.
    always_comb begin
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_pc_d    = m_pc_q;
        s_valid_d = s_valid_q;
        s_instr_d = s_instr_q;
        s_pc_d    = s_pc_q;

        if (flush) begin
            // Only the valid flags are cleared. Stale data is harmless.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            case ({m_valid_q, s_valid_q})
                2'b00: begin
                    if (accept_s) begin
                        m_valid_d = 1'b1;
                        m_instr_d = if_instruction;
                        m_pc_d    = if_pc;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (consume_s && accept_s) begin
                        m_instr_d = if_instruction;
                        m_pc_d    = if_pc;
                    end else if (consume_s) begin
                        m_valid_d = 1'b0;
                    end else if (accept_s) begin
                        // Decode stalled: park the newer word behind main.
                        s_valid_d = 1'b1;
                        s_instr_d = if_instruction;
                        s_pc_d    = if_pc;
                    end else begin
                        m_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // if_ready is low here, so only draining is possible.
                    if (consume_s) begin
                        m_instr_d = s_instr_q;
                        m_pc_d    = s_pc_q;
                        s_valid_d = 1'b0;
                    end else begin
                        s_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable. Drop to empty so a corrupted
                    // state cannot emit an out-of-order instruction.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset that overrides flush and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_instr_q <= '0;
            m_pc_q    <= '0;
            s_valid_q <= 1'b0;
            s_instr_q <= '0;
            s_pc_q    <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            s_valid_q <= s_valid_d;
            s_instr_q <= s_instr_d;
            s_pc_q    <= s_pc_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed table of single-cycle vectors covering streaming, stall/skid,
// flush and mid-stream reset, plus field checks on two known encodings. It
// is followed by a long random handshake run against an occupancy and
// sequence model.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [4:0]  if_pc;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [4:0]  id_pc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic        id_is_rtype;

    int n_tests;
    int n_fail;

    if_id_stage #(.PC_WIDTH(5), .INSTR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .flush          (flush),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_funct       (id_funct),
        .id_is_rtype    (id_is_rtype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] ins;
        logic [4:0]  pc;
        logic        idr;
        logic        e_v;
        logic        e_rdy;
        logic        chk_d;
        logic [31:0] e_ins;
        logic [4:0]  e_pc;
        logic        e_rt;
    } vec_t;

    localparam logic [31:0] I0  = 32'h00221820;
    localparam logic [31:0] I1  = 32'h00A41022;
    localparam logic [31:0] I2  = 32'h8C010004;
    localparam logic [31:0] I3  = 32'h00031080;
    localparam logic [31:0] I4  = 32'h01095020;
    localparam logic [31:0] I5  = 32'h20420001;
    localparam logic [31:0] I6  = 32'h014B6024;
    localparam logic [31:0] I7  = 32'hAC220008;
    localparam logic [31:0] I8  = 32'h00851025;
    localparam logic [31:0] I9  = 32'h8C430010;
    localparam logic [31:0] I10 = 32'h00C72820;
    localparam logic [31:0] I11 = 32'h10A00003;

    vec_t vecs[20];

    initial begin
        int unsigned seq;
        int unsigned cons_seq;
        int          occ;
        logic        acc;
        logic        con;

        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        flush          = 1'b0;
        if_valid       = 1'b0;
        if_instruction = 32'h0;
        if_pc          = 5'd0;
        id_ready       = 1'b0;

        //            rst   fl    iv    ins        pc     idr   e_v   e_rdy chk_d e_ins      e_pc   e_rt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0,  1'b0};
        // streaming with decode always ready
        vecs[1]  = '{1'b0, 1'b0, 1'b1, I0,    5'd0,  1'b1, 1'b1, 1'b1, 1'b1, I0,    5'd0,  1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, I1,    5'd1,  1'b1, 1'b1, 1'b1, 1'b1, I1,    5'd1,  1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, I2,    5'd2,  1'b1, 1'b1, 1'b1, 1'b1, I2,    5'd2,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0,  1'b0};
        // stall: second word goes to skid, third is refused, then drain
        vecs[5]  = '{1'b0, 1'b0, 1'b1, I3,    5'd3,  1'b0, 1'b1, 1'b1, 1'b1, I3,    5'd3,  1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, I4,    5'd4,  1'b0, 1'b1, 1'b0, 1'b1, I3,    5'd3,  1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, I5,    5'd5,  1'b0, 1'b1, 1'b0, 1'b1, I3,    5'd3,  1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, I4,    5'd4,  1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0,  1'b0};
        // fill both entries, then flush with an incoming word
        vecs[10] = '{1'b0, 1'b0, 1'b1, I5,    5'd5,  1'b0, 1'b1, 1'b1, 1'b1, I5,    5'd5,  1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, I6,    5'd6,  1'b0, 1'b1, 1'b0, 1'b1, I5,    5'd5,  1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, I7,    5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0,  1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0,  1'b0};
        // fill both entries, then reset (with flush/handshake active)
        vecs[14] = '{1'b0, 1'b0, 1'b1, I8,    5'd8,  1'b0, 1'b1, 1'b1, 1'b1, I8,    5'd8,  1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, I9,    5'd9,  1'b0, 1'b1, 1'b0, 1'b1, I8,    5'd8,  1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, I10,   5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0,  1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, I10,   5'd10, 1'b1, 1'b1, 1'b1, 1'b1, I10,   5'd10, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, I11,   5'd11, 1'b1, 1'b1, 1'b1, 1'b1, I11,   5'd11, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0,  1'b0};

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            reset          = vecs[i].rst;
            flush          = vecs[i].fl;
            if_valid       = vecs[i].iv;
            if_instruction = vecs[i].ins;
            if_pc          = vecs[i].pc;
            id_ready       = vecs[i].idr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d id_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_v});
            check($sformatf("v%0d if_ready", i), {31'h0, if_ready}, {31'h0, vecs[i].e_rdy});
            check($sformatf("v%0d id_is_rtype", i), {31'h0, id_is_rtype}, {31'h0, vecs[i].e_rt});
            if (vecs[i].chk_d) begin
                check($sformatf("v%0d id_instruction", i), id_instruction, vecs[i].e_ins);
                check($sformatf("v%0d id_pc", i), {27'h0, id_pc}, {27'h0, vecs[i].e_pc});
            end
            if (i == 0) begin
                check("reset fields", {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, 32'h0);
            end
            if (i == 1) begin
                check("add opcode", {26'h0, id_opcode}, 32'd0);
                check("add rs",     {27'h0, id_rs},     32'd1);
                check("add rt",     {27'h0, id_rt},     32'd2);
                check("add rd",     {27'h0, id_rd},     32'd3);
                check("add shamt",  {27'h0, id_shamt},  32'd0);
                check("add funct",  {26'h0, id_funct},  32'h20);
            end
            if (i == 5) begin
                check("sll rt",    {27'h0, id_rt},    32'd3);
                check("sll rd",    {27'h0, id_rd},    32'd2);
                check("sll shamt", {27'h0, id_shamt}, 32'd2);
                check("sll funct", {26'h0, id_funct}, 32'd0);
            end
            @(negedge clk);
        end

        // Random handshake run: the DUT ends the table empty.
        reset    = 1'b0;
        flush    = 1'b0;
        seq      = 0;
        cons_seq = 0;
        occ      = 0;
        for (int c = 0; c < 1500; c++) begin
            if_valid       = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            if_instruction = 32'h5A000000 | (seq & 32'h00FFFFFF);
            if_pc          = seq[4:0];
            #1;
            check("rnd if_ready", {31'h0, if_ready}, {31'h0, (occ < 2)});
            check("rnd id_valid", {31'h0, id_valid}, {31'h0, (occ > 0)});
            acc = if_valid && (occ < 2);
            con = (occ > 0) && id_ready;
            if (con) begin
                check("rnd id_pc", {27'h0, id_pc}, {27'h0, cons_seq[4:0]});
                check("rnd id_instruction", id_instruction, 32'h5A000000 | (cons_seq & 32'h00FFFFFF));
                cons_seq++;
            end
            if (acc) seq++;
            occ = occ + (acc ? 1 : 0) - (con ? 1 : 0);
            @(negedge clk);
        end
        check("rnd traffic seen", {31'h0, (cons_seq > 32'd500)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
